code_lock_core: RTL and testbench
=================================

# code_lock_core

Parametrised bomb-defusal controller: N sequential code stages of configurable width, a per-stage attempt limit and an internal millisecond countdown. It replaces the fixed two-stage lock logic and external countdown timer in the game top level. The top level keeps the key edge detection, 7-segment drivers and LED formatting, and feeds this block single-cycle `start`/`enter` strobes and the 1 ms tick.

## Interface
- `NUM_STAGES`, 2: number of code stages, 1..8.
- `CODE_W`, 4: bits per stage code and per guess, 1..8.
- `MAX_TRIES`, 7: wrong guesses allowed per stage before explosion, 1..15.
- `TIME_MS`, 90000: countdown start value in ms, 1..2^20-1.
- `PENALTY_MS`, 5000: time deducted per wrong guess (only with `PENALTY_EN`).
- `clk` in 1: system clock (CLOCK_50 at the top level).
- `reset` in 1: synchronous, active-high.
- `tick_1ms` in 1: one-cycle strobe every 1 ms.
- `start` in 1: one-cycle strobe; arms the bomb from SETUP.
- `enter` in 1: one-cycle strobe; submits `guess`.
- `setup_code` in NUM_STAGES*CODE_W: stage k code in bits [k*CODE_W +: CODE_W].
- `guess` in CODE_W: current switch value.
- `state` out 2: 0 SETUP, 1 ARMED, 2 DEFUSED, 3 EXPLODED.
- `stage` out clog2(NUM_STAGES+1): index of the active stage; NUM_STAGES when DEFUSED.
- `tries_left` out 4: remaining wrong guesses in the active stage.
- `time_left_ms` out 20: remaining time.
- `last_guess` out CODE_W: last submitted guess of the active stage.
- `hint_cmp` out 2: 00 none, 01 secret higher, 10 secret lower, 11 equal.
- `hint_parity` out 1: parity (XOR) of the active stage's secret.
- `guess_strobe` out 1: one-cycle pulse when a guess is evaluated.

## Operation
- Reset state: SETUP; stage=0, tries_left=0, time_left_ms=0, last_guess=0, hint_cmp=00, guess_strobe=0, and all latched codes cleared. `hint_parity` is 0 because it derives from the cleared code.
- SETUP: `enter` is ignored. On `start`:
  - latch `setup_code`;
  - set time_left_ms=TIME_MS, tries_left=MAX_TRIES, stage=0;
  - go to ARMED.
- ARMED, on `tick_1ms`: decrement time_left_ms. If the decrement reaches 0, go to EXPLODED.
- ARMED, on `enter`: register `guess` into last_guess, pulse guess_strobe and set hint_cmp.
  - Correct guess: hint_cmp=11. If the stage is the last one, go to DEFUSED. Otherwise stage+1, tries_left reloads to MAX_TRIES, last_guess clears to 0 and hint_cmp clears to 00.
  - Wrong guess: hint_cmp=01 or 10. If tries_left=0, go to EXPLODED; otherwise decrement tries_left.
- Simultaneous tick and enter in ARMED: both apply in the same cycle. If the time result is 0, EXPLODED has priority over any guess outcome, including a correct last stage.
- DEFUSED and EXPLODED: time_left_ms freezes. Only `reset` leaves these states; `start` is ignored.
- `start` while ARMED is ignored. Codes cannot be changed after arming.
- `reset` mid-game returns to the reset state in the next cycle, regardless of pending strobes.

## Timing
- All outputs are registered. A guess result appears 1 cycle after the `enter` cycle, coincident with guess_strobe.
- `start` to ARMED takes 1 cycle.
- The timeout transition occurs in the cycle after the tick that reaches 0.
- `hint_parity` is combinational from the latched code and the registered stage, so it carries no extra latency.
- Back-to-back `enter` strobes on consecutive cycles are each evaluated. For the second strobe, the stage is the one updated by the first.

## Configuration
- `CODE_LOCK_PENALTY_EN` defined:
  - a wrong guess also subtracts PENALTY_MS from time_left_ms, saturating at 0;
  - saturation to 0 goes to EXPLODED in the same update;
  - a same-cycle tick is applied after the penalty (still saturating).
- `CODE_LOCK_PENALTY_EN` undefined: wrong guesses do not affect time, and PENALTY_MS is unused.

## Structure
- Shared package `code_lock_pkg`: state encoding constants, hint_cmp encodings, and the 20-bit time width constant.
- One sub-module, `ms_countdown`:
  - loadable saturating down-counter with `load`, `dec_tick`, `dec_amount` (penalty) and `freeze` inputs;
  - outputs `zero`.
- The stage/tries FSM and the comparator stay in `code_lock_core`.

## Test plan
- NUM_STAGES=3, CODE_W=4, codes {5,A,3}: start, then enter 5, A, 3 → stage 0→1→2, then state=DEFUSED with stage=3. time_left_ms frozen thereafter.
- Stage 0 code 9: guesses 2 then F → hint_cmp 01 then 10, tries_left 7→6→5. Guess 9 → stage=1, tries_left=7, hint_cmp=00.
- MAX_TRIES=2, 3 wrong guesses in stage 0 → EXPLODED on the third guess strobe; further enters have no effect.
- TIME_MS=3, no guesses → time_left_ms 3,2,1,0 across three ticks, EXPLODED one cycle after the third tick. The same run with a correct last-stage enter on the third tick cycle → EXPLODED.
- With CODE_LOCK_PENALTY_EN, TIME_MS=6000, PENALTY_MS=5000: two wrong guesses → 1000, then 0 and EXPLODED. Without the macro, the same stimulus leaves time at 6000.
- Reset asserted mid-ARMED during an enter strobe → all outputs at reset values next cycle, state=SETUP. A new start re-latches the codes.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared encodings for the code lock: game states, hint codes, countdown width.
package code_lock_pkg;

  localparam int unsigned TimeW = 20;

  typedef enum logic [1:0] {
    StSetup    = 2'd0,
    StArmed    = 2'd1,
    StDefused  = 2'd2,
    StExploded = 2'd3
  } lock_state_e;

  localparam logic [1:0] HintNone   = 2'b00;
  localparam logic [1:0] HintHigher = 2'b01;  // secret is higher than the guess
  localparam logic [1:0] HintLower  = 2'b10;  // secret is lower than the guess
  localparam logic [1:0] HintEqual  = 2'b11;

  // Operands are zero-extended to 8 bits so one helper serves every code width.
  function automatic logic [1:0] cmp_hint(logic [7:0] secret, logic [7:0] guess);
    if (secret == guess) return HintEqual;
    else if (secret > guess) return HintHigher;
    else return HintLower;
  endfunction

endpackage

// File: rtl/ms_countdown.sv
// Loadable saturating millisecond down-counter. A penalty amount and a one-tick
// decrement may land in the same cycle; the penalty is applied first.
// `zero` flags that this cycle's decrement lands on zero (the count shows it next cycle).
module ms_countdown #(
  parameter int unsigned Width = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec_tick,
  input  logic [Width-1:0] dec_amount,
  input  logic             freeze,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d, after_pen, after_tick;
  logic             active;

  // Next count: load wins, otherwise saturating penalty then saturating tick.
  always_comb begin
    after_pen  = (count_q >= dec_amount) ? count_q - dec_amount : '0;
    after_tick = (dec_tick && after_pen != '0) ? after_pen - 1'b1 : after_pen;
    active     = !freeze && (dec_tick || dec_amount != '0);
    count_d    = count_q;
    if (load) count_d = load_val;
    else if (active) count_d = after_tick;
    zero = !load && active && (after_tick == '0);
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/code_lock_core.sv
// Multi-stage code lock with per-stage attempt limit and a millisecond countdown.
// Optional feature: define CODE_LOCK_PENALTY_EN to deduct PENALTY_MS per wrong guess.
module code_lock_core
  import code_lock_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned MAX_TRIES  = 7,
  parameter int unsigned TIME_MS    = 90000,
  parameter int unsigned PENALTY_MS = 5000,
  localparam int unsigned StageW    = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick_1ms,
  input  logic                         start,
  input  logic                         enter,
  input  logic [NUM_STAGES*CODE_W-1:0] setup_code,
  input  logic [CODE_W-1:0]            guess,
  output logic [1:0]                   state,
  output logic [StageW-1:0]            stage,
  output logic [3:0]                   tries_left,
  output logic [TimeW-1:0]             time_left_ms,
  output logic [CODE_W-1:0]            last_guess,
  output logic [1:0]                   hint_cmp,
  output logic                         hint_parity,
  output logic                         guess_strobe
);

`ifdef CODE_LOCK_PENALTY_EN
  localparam bit PenaltyEn = 1'b1;
`else
  localparam bit PenaltyEn = 1'b0;
`endif

  lock_state_e                  state_q, state_d;
  logic [StageW-1:0]            stage_q, stage_d;
  logic [3:0]                   tries_q, tries_d;
  logic [CODE_W-1:0]            last_q, last_d, secret;
  logic [1:0]                   hint_q, hint_d;
  logic                         strobe_q, strobe_d;
  logic [NUM_STAGES*CODE_W-1:0] codes_q, codes_d;
  logic                         armed, match, wrong, last_stage;
  logic                         cd_load, cd_tick, cd_zero;
  logic [TimeW-1:0]             cd_amount, time_q;

  // Secret of the active stage; zero once every stage is done.
  always_comb begin
    secret = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_q == StageW'(k)) secret = codes_q[k*CODE_W +: CODE_W];
    end
  end

  assign armed      = (state_q == StArmed);
  assign match      = (guess == secret);
  assign wrong      = armed && enter && !match;
  assign last_stage = (stage_q == StageW'(NUM_STAGES - 1));
  assign cd_load    = (state_q == StSetup) && start;
  assign cd_tick    = armed && tick_1ms;
  assign cd_amount  = (PenaltyEn && wrong) ? TimeW'(PENALTY_MS) : '0;

  ms_countdown #(
    .Width(TimeW)
  ) u_countdown (
    .clk       (clk),
    .reset     (reset),
    .load      (cd_load),
    .load_val  (TimeW'(TIME_MS)),
    .dec_tick  (cd_tick),
    .dec_amount(cd_amount),
    .freeze    (!armed),
    .count     (time_q),
    .zero      (cd_zero)
  );

  // Game FSM: arming, guess evaluation, stage advance and explosion.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    tries_d  = tries_q;
    last_d   = last_q;
    hint_d   = hint_q;
    strobe_d = 1'b0;
    codes_d  = codes_q;
    unique case (state_q)
      StSetup: begin
        if (start) begin
          codes_d = setup_code;
          tries_d = 4'(MAX_TRIES);
          stage_d = '0;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (enter) begin
          last_d   = guess;
          strobe_d = 1'b1;
          hint_d   = cmp_hint(8'(secret), 8'(guess));
        end
        // Running out of time overrides whatever the guess would have done.
        if (cd_zero) begin
          state_d = StExploded;
        end else if (enter && match) begin
          stage_d = stage_q + 1'b1;
          if (last_stage) begin
            state_d = StDefused;
          end else begin
            tries_d = 4'(MAX_TRIES);
            last_d  = '0;
            hint_d  = HintNone;
          end
        end else if (enter) begin
          if (tries_q == 4'd0) state_d = StExploded;
          else tries_d = tries_q - 4'd1;
        end
      end
      default: ;  // StDefused / StExploded hold until reset
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StSetup;
      stage_q  <= '0;
      tries_q  <= '0;
      last_q   <= '0;
      hint_q   <= HintNone;
      strobe_q <= 1'b0;
      codes_q  <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      tries_q  <= tries_d;
      last_q   <= last_d;
      hint_q   <= hint_d;
      strobe_q <= strobe_d;
      codes_q  <= codes_d;
    end
  end

  assign state        = state_q;
  assign stage        = stage_q;
  assign tries_left   = tries_q;
  assign time_left_ms = time_q;
  assign last_guess   = last_q;
  assign hint_cmp     = hint_q;
  assign hint_parity  = ^secret;
  assign guess_strobe = strobe_q;

endmodule

// File: tb/tb_code_lock_core.sv
// Bench for code_lock_core: a 3-stage instance (table + random vs. behavioural model)
// and a 2-stage, 2-try, 3 ms instance for the attempt-limit and timeout corners.
module tb_code_lock_core;

`ifdef CODE_LOCK_PENALTY_EN
  localparam int P = 5000;
`else
  localparam int P = 0;
`endif
  localparam int ATime = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A: 3 stages, 7 tries, 6000 ms ----------------
  logic        a_reset = 1'b0, a_tick = 1'b0, a_start = 1'b0, a_enter = 1'b0;
  logic [11:0] a_sc = '0;
  logic [3:0]  a_guess = '0;
  logic [1:0]  a_state, a_hint;
  logic [1:0]  a_stage;
  logic [3:0]  a_tries, a_last;
  logic [19:0] a_time;
  logic        a_par, a_strobe;

  code_lock_core #(
    .NUM_STAGES(3), .CODE_W(4), .MAX_TRIES(7), .TIME_MS(ATime), .PENALTY_MS(5000)
  ) dut_a (
    .clk(clk), .reset(a_reset), .tick_1ms(a_tick), .start(a_start), .enter(a_enter),
    .setup_code(a_sc), .guess(a_guess), .state(a_state), .stage(a_stage),
    .tries_left(a_tries), .time_left_ms(a_time), .last_guess(a_last), .hint_cmp(a_hint),
    .hint_parity(a_par), .guess_strobe(a_strobe)
  );

  // ---------------- instance B: 2 stages, 2 tries, 3 ms, no penalty ----------------
  logic        b_reset = 1'b0, b_tick = 1'b0, b_start = 1'b0, b_enter = 1'b0;
  logic [7:0]  b_sc = 8'h21;
  logic [3:0]  b_guess = '0;
  logic [1:0]  b_state, b_hint, b_stage;
  logic [3:0]  b_tries, b_last;
  logic [19:0] b_time;
  logic        b_par, b_strobe;

  code_lock_core #(
    .NUM_STAGES(2), .CODE_W(4), .MAX_TRIES(2), .TIME_MS(3), .PENALTY_MS(0)
  ) dut_b (
    .clk(clk), .reset(b_reset), .tick_1ms(b_tick), .start(b_start), .enter(b_enter),
    .setup_code(b_sc), .guess(b_guess), .state(b_state), .stage(b_stage),
    .tries_left(b_tries), .time_left_ms(b_time), .last_guess(b_last), .hint_cmp(b_hint),
    .hint_parity(b_par), .guess_strobe(b_strobe)
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural reference for instance A ----------------
  int m_state, m_stage, m_tries, m_time, m_last, m_hint, m_strobe;
  int m_code[3];

  task automatic model_step(bit r, bit s, bit e, bit t, logic [3:0] g, logic [11:0] sc);
    int nt;
    bit cor, wr;
    m_strobe = 0;
    if (r) begin
      m_state = 0; m_stage = 0; m_tries = 0; m_time = 0; m_last = 0; m_hint = 0;
      for (int k = 0; k < 3; k++) m_code[k] = 0;
    end else if (m_state == 0) begin
      if (s) begin
        for (int k = 0; k < 3; k++) m_code[k] = int'(sc[k*4 +: 4]);
        m_time = ATime; m_tries = 7; m_stage = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      cor = e && (int'(g) == m_code[m_stage]);
      wr  = e && !cor;
      nt  = m_time;
      if (wr) nt = (nt > P) ? nt - P : 0;
      if (t && nt > 0) nt = nt - 1;
      m_time = nt;
      if (e) begin
        m_last = int'(g); m_strobe = 1;
        m_hint = cor ? 3 : (m_code[m_stage] > int'(g)) ? 1 : 2;
      end
      if (nt == 0) m_state = 3;
      else if (cor) begin
        m_stage = m_stage + 1;
        if (m_stage == 3) m_state = 2;
        else begin m_tries = 7; m_last = 0; m_hint = 0; end
      end else if (wr) begin
        if (m_tries == 0) m_state = 3;
        else m_tries = m_tries - 1;
      end
    end
  endtask

  function automatic int model_parity();
    logic [3:0] c;
    if (m_stage >= 3) return 0;
    c = 4'(m_code[m_stage]);
    return int'(^c);
  endfunction

  // One clock on instance A: drive, advance the model, sample 1 time unit after the edge.
  task automatic cyc_a(bit r, bit s, bit e, bit t, logic [3:0] g, logic [11:0] sc);
    a_reset = r; a_start = s; a_enter = e; a_tick = t; a_guess = g; a_sc = sc;
    model_step(r, s, e, t, g, sc);
    @(posedge clk);
    #1;
    chk("model.state", 32'(a_state), m_state);
    chk("model.stage", 32'(a_stage), m_stage);
    chk("model.tries", 32'(a_tries), m_tries);
    chk("model.time", 32'(a_time), m_time);
    chk("model.last", 32'(a_last), m_last);
    chk("model.hint", 32'(a_hint), m_hint);
    chk("model.strobe", 32'(a_strobe), m_strobe);
    chk("model.parity", 32'(a_par), model_parity());
  endtask

  task automatic cyc_b(bit r, bit s, bit e, bit t, logic [3:0] g);
    b_reset = r; b_start = s; b_enter = e; b_tick = t; b_guess = g;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_b(string tag, int st, int stg, int tr, int tm, int strb);
    chk({tag, ".state"}, 32'(b_state), st);
    chk({tag, ".stage"}, 32'(b_stage), stg);
    chk({tag, ".tries"}, 32'(b_tries), tr);
    chk({tag, ".time"}, 32'(b_time), tm);
    chk({tag, ".strobe"}, 32'(b_strobe), strb);
  endtask

  typedef struct {
    bit r, s, e, t;
    logic [3:0] g;
    logic [11:0] sc;
    int st, stg, tr, tm, hint, strb, last, par;
  } vec_t;

  vec_t tv[18];

  initial begin
    bit pen;
    logic [11:0] sc;
    pen = (P != 0);

    //        r  s  e  t  g      sc       st           stg         tr          tm
    tv[0]  = '{1, 0, 0, 0, 4'h0, 12'h3A5, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 1, 0, 4'h5, 12'h3A5, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 1, 0, 0, 4'h0, 12'h3A5, 1, 0, 7, 6000, 0, 0, 0, 0};
    tv[3]  = '{0, 1, 0, 0, 4'h0, 12'h3A5, 1, 0, 7, 6000, 0, 0, 0, 0};
    tv[4]  = '{0, 0, 1, 0, 4'h5, 12'h3A5, 1, 1, 7, 6000, 0, 1, 0, 0};
    tv[5]  = '{0, 0, 1, 0, 4'hA, 12'h3A5, 1, 2, 7, 6000, 0, 1, 0, 0};
    tv[6]  = '{0, 0, 0, 1, 4'h0, 12'h3A5, 1, 2, 7, 5999, 0, 0, 0, 0};
    tv[7]  = '{0, 0, 1, 0, 4'h3, 12'h3A5, 2, 3, 7, 5999, 3, 1, 3, 0};
    tv[8]  = '{0, 0, 0, 1, 4'h0, 12'h3A5, 2, 3, 7, 5999, 3, 0, 3, 0};
    tv[9]  = '{0, 1, 0, 0, 4'h0, 12'h3A5, 2, 3, 7, 5999, 3, 0, 3, 0};
    tv[10] = '{1, 0, 0, 0, 4'h0, 12'h479, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[11] = '{0, 1, 0, 0, 4'h0, 12'h479, 1, 0, 7, 6000, 0, 0, 0, 0};
    tv[12] = '{0, 0, 1, 0, 4'h2, 12'h479, 1, 0, 6, 6000 - P, 1, 1, 2, 0};
    tv[13] = '{0, 0, 1, 0, 4'hF, 12'h479, pen ? 3 : 1, 0, pen ? 6 : 5, pen ? 0 : 6000,
               2, 1, 15, 0};
    tv[14] = '{0, 0, 1, 0, 4'h9, 12'h479, pen ? 3 : 1, pen ? 0 : 1, pen ? 6 : 7,
               pen ? 0 : 6000, pen ? 2 : 0, pen ? 0 : 1, pen ? 15 : 0, pen ? 0 : 1};
    tv[15] = '{1, 0, 1, 0, 4'h7, 12'h479, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[16] = '{0, 1, 0, 0, 4'h0, 12'hEBC, 1, 0, 7, 6000, 0, 0, 0, 0};
    tv[17] = '{0, 0, 1, 0, 4'hC, 12'hEBC, 1, 1, 7, 6000, 0, 1, 0, 1};

    for (int i = 0; i < 18; i++) begin
      cyc_a(tv[i].r, tv[i].s, tv[i].e, tv[i].t, tv[i].g, tv[i].sc);
      chk($sformatf("tv%0d.state", i), 32'(a_state), tv[i].st);
      chk($sformatf("tv%0d.stage", i), 32'(a_stage), tv[i].stg);
      chk($sformatf("tv%0d.tries", i), 32'(a_tries), tv[i].tr);
      chk($sformatf("tv%0d.time", i), 32'(a_time), tv[i].tm);
      chk($sformatf("tv%0d.hint", i), 32'(a_hint), tv[i].hint);
      chk($sformatf("tv%0d.strobe", i), 32'(a_strobe), tv[i].strb);
      chk($sformatf("tv%0d.last", i), 32'(a_last), tv[i].last);
      chk($sformatf("tv%0d.parity", i), 32'(a_par), tv[i].par);
    end

    // Random episodes, guesses biased towards the active secret.
    for (int ep = 0; ep < 25; ep++) begin
      sc = 12'($urandom);
      cyc_a(1, 0, 0, 0, 4'h0, sc);
      cyc_a(0, 1, 0, 0, 4'h0, sc);
      for (int i = 0; i < 60; i++) begin
        logic [3:0] g;
        if ($urandom_range(0, 1) == 1) g = 4'(m_code[(m_stage < 3) ? m_stage : 0]);
        else g = 4'($urandom);
        cyc_a($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, g, 12'($urandom));
      end
    end

    // Attempt limit: two tries, the third wrong guess explodes; later enters do nothing.
    cyc_b(1, 0, 0, 0, 4'h0);  exp_b("b_rst", 0, 0, 0, 0, 0);
    cyc_b(0, 1, 0, 0, 4'h0);  exp_b("b_arm", 1, 0, 2, 3, 0);
    cyc_b(0, 0, 1, 0, 4'h0);  exp_b("b_w1", 1, 0, 1, 3, 1);
    chk("b_w1.hint", 32'(b_hint), 1);
    cyc_b(0, 0, 1, 0, 4'h3);  exp_b("b_w2", 1, 0, 0, 3, 1);
    chk("b_w2.hint", 32'(b_hint), 2);
    cyc_b(0, 0, 1, 0, 4'h4);  exp_b("b_w3", 3, 0, 0, 3, 1);
    cyc_b(0, 0, 1, 0, 4'h1);  exp_b("b_dead", 3, 0, 0, 3, 0);
    chk("b_dead.last", 32'(b_last), 4);

    // Timeout: 3 ticks, EXPLODED together with time reaching 0, then frozen.
    cyc_b(1, 0, 0, 0, 4'h0);
    cyc_b(0, 1, 0, 0, 4'h0);  exp_b("b_t0", 1, 0, 2, 3, 0);
    cyc_b(0, 0, 0, 1, 4'h0);  exp_b("b_t1", 1, 0, 2, 2, 0);
    cyc_b(0, 0, 0, 1, 4'h0);  exp_b("b_t2", 1, 0, 2, 1, 0);
    cyc_b(0, 0, 0, 1, 4'h0);  exp_b("b_t3", 3, 0, 2, 0, 0);
    cyc_b(0, 1, 0, 1, 4'h0);  exp_b("b_t4", 3, 0, 2, 0, 0);

    // Timeout coinciding with a correct last-stage guess still explodes.
    cyc_b(1, 0, 0, 0, 4'h0);
    cyc_b(0, 1, 0, 0, 4'h0);
    cyc_b(0, 0, 1, 0, 4'h1);  exp_b("b_s1", 1, 1, 2, 3, 1);
    cyc_b(0, 0, 0, 1, 4'h0);  exp_b("b_s2", 1, 1, 2, 2, 0);
    cyc_b(0, 0, 0, 1, 4'h0);  exp_b("b_s3", 1, 1, 2, 1, 0);
    cyc_b(0, 0, 1, 1, 4'h2);
    chk("b_race.state", 32'(b_state), 3);
    chk("b_race.time", 32'(b_time), 0);
    cyc_b(0, 0, 0, 0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
